// File: rtl/locked_adder_ctrl.sv
// locked_adder_ctrl
//    Controller around an XOR-locked 32-bit ripple-carry adder. A 64-bit key is
//    loaded one byte at a time. Once all eight bytes are in, two requesters
//    compete for the adder through a round-robin arbiter. Each accepted
//    operation produces one registered 33-bit response. Sums are correct only
//    when the loaded key matches the key the adder core was locked with.
//
// Ports
//    clk_i         clock; all state changes on its rising edge
//    rst_i         asynchronous active-high reset
//    key_byte_i    serial key byte; byte k fills key bits [8k+7:8k]
//    key_valid_i   key_byte_i valid (used only while LOCKED)
//    key_clear_i   zeroise the key, drop any work in flight, relock
//    req_valid_i   per-requester request (2 bits)
//    req_a_i/b_i   packed operands; requester r uses bits [32r+31:32r]
//    req_ready_o   one-hot grant, nonzero only while arbitrating
//    rsp_valid_o   response available
//    rsp_ready_i   response consumer ready
//    rsp_sum_o     33-bit sum (carry-out in bit 32)
//    rsp_id_o      requester index of the response
//    key_loaded_o  all eight key bytes loaded
//    op_count_o    completed responses, modulo 2^OPCNT_W

// locked_adder_core
//    Combinational 32-bit ripple-carry adder. Every propagate term and every
//    carry is passed through an XOR with one key bit. The key bits undo a
//    built-in inversion only when keyinput equals the golden key.
//
// Ports
//    a, b      32-bit operands
//    keyinput  64-bit unlock key; bits [31:0] lock the propagates,
//              bits [63:32] lock the carries
//    sum       33-bit result
module locked_adder_core (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] keyinput,
   output logic [32:0] sum
);
   localparam logic [63:0] KEY_GOLD = 64'hA5C3_0F96_3C5A_E178;

   logic [32:0] carry;
   logic [31:0] prop;
   logic [31:0] bit_sum;

   assign carry[0] = 1'b0;

   for (genvar gi = 0; gi < 32; gi++) begin : g_stage
      // A key bit that differs from the golden bit inverts the net.
      assign prop[gi]      = a[gi] ^ b[gi] ^ keyinput[gi] ^ KEY_GOLD[gi];
      assign bit_sum[gi]   = prop[gi] ^ carry[gi];
      assign carry[gi + 1] = ((a[gi] & b[gi]) | (prop[gi] & carry[gi]))
                             ^ keyinput[32 + gi] ^ KEY_GOLD[32 + gi];
   end

   assign sum = {carry[32], bit_sum};
endmodule

module locked_adder_ctrl #(
   parameter bit RR_INIT = 1'b0,
   parameter int OPCNT_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [7:0]         key_byte_i,
   input  logic               key_valid_i,
   input  logic               key_clear_i,
   input  logic [1:0]         req_valid_i,
   input  logic [63:0]        req_a_i,
   input  logic [63:0]        req_b_i,
   output logic [1:0]         req_ready_o,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [32:0]        rsp_sum_o,
   output logic               rsp_id_o,
   output logic               key_loaded_o,
   output logic [OPCNT_W-1:0] op_count_o
);
   typedef enum logic [1:0] {LOCKED, ARB, CALC, RESP} state_t;

   state_t              state;
   state_t              state_next;
   logic [63:0]         key;
   logic [2:0]          byte_cnt;
   logic                key_loaded;
   logic                prio;        // requester that wins a tie
   logic [31:0]         op_a;
   logic [31:0]         op_b;
   logic [32:0]         rsp_sum;
   logic                rsp_id;
   logic [OPCNT_W-1:0]  op_count;
   logic [1:0]          grant;
   logic                transfer;
   logic                grant_id;
   logic                key_write;
   logic [32:0]         core_sum;

   locked_adder_core u_core (
      .a        (op_a),
      .b        (op_b),
      .keyinput (key),
      .sum      (core_sum)
   );

   // Grant depends only on state, request lines and priority pointer.
   always_comb begin
      grant = 2'b00;
      if (state == ARB) begin
         unique case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign transfer  = |(req_valid_i & grant);
   assign grant_id  = grant[1];
   assign key_write = (state == LOCKED) && key_valid_i && !key_clear_i;

   always_comb begin
      state_next = state;
      unique case (state)
         LOCKED: if (key_valid_i && (byte_cnt == 3'd7)) state_next = ARB;
         ARB:    if (transfer)                           state_next = CALC;
         CALC:                                           state_next = RESP;
         RESP:   if (rsp_ready_i)                        state_next = ARB;
         default:                                        state_next = LOCKED;
      endcase
      // Clearing the key overrides every other transition.
      if (key_clear_i) state_next = LOCKED;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= LOCKED;
      else       state <= state_next;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         key        <= '0;
         byte_cnt   <= '0;
         key_loaded <= 1'b0;
         prio       <= RR_INIT;
         op_a       <= '0;
         op_b       <= '0;
         rsp_sum    <= '0;
         rsp_id     <= 1'b0;
         op_count   <= '0;
      end else if (key_clear_i) begin
         // A byte arriving together with the clear is discarded.
         key        <= '0;
         byte_cnt   <= '0;
         key_loaded <= 1'b0;
      end else begin
         if (key_write) begin
            key[{byte_cnt, 3'b000} +: 8] <= key_byte_i;
            byte_cnt                     <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) key_loaded <= 1'b1;
         end
         if (transfer) begin
            op_a   <= grant_id ? req_a_i[63:32] : req_a_i[31:0];
            op_b   <= grant_id ? req_b_i[63:32] : req_b_i[31:0];
            rsp_id <= grant_id;
            prio   <= ~grant_id;
         end
         if (state == CALC) rsp_sum <= core_sum;
         if ((state == RESP) && rsp_ready_i) op_count <= op_count + OPCNT_W'(1);
      end
   end

   assign req_ready_o  = grant;
   assign rsp_valid_o  = (state == RESP);
   assign rsp_sum_o    = rsp_sum;
   assign rsp_id_o     = rsp_id;
   assign key_loaded_o = key_loaded;
   assign op_count_o   = op_count;
endmodule

// File: tb/tb_locked_adder_ctrl.sv
module tb_locked_adder_ctrl;
   localparam logic [63:0] GOLD_KEY = 64'hA5C3_0F96_3C5A_E178;
   localparam int OPW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     key_byte;
   logic           key_valid;
   logic           key_clear;
   logic [1:0]     req_valid;
   logic [63:0]    req_a;
   logic [63:0]    req_b;
   logic [1:0]     req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [32:0]    rsp_sum;
   logic           rsp_id;
   logic           key_loaded;
   logic [OPW-1:0] op_count;

   locked_adder_ctrl #(.RR_INIT(1'b0), .OPCNT_W(OPW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .key_byte_i   (key_byte),
      .key_valid_i  (key_valid),
      .key_clear_i  (key_clear),
      .req_valid_i  (req_valid),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_sum_o    (rsp_sum),
      .rsp_id_o     (rsp_id),
      .key_loaded_o (key_loaded),
      .op_count_o   (op_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: 0 LOCKED, 1 ARB, 2 CALC, 3 RESP
   int             m_state = 0;
   logic [2:0]     m_cnt = '0;
   logic           m_loaded = 1'b0;
   logic           m_prio = 1'b0;
   logic [OPW-1:0] m_ops = '0;
   logic [33:0]    sb[$];           // {id, sum}
   int             xfer_count = 0;
   int             done_count = 0;
   int             last_gid = 0;

   always @(negedge clk) begin
      logic [1:0]  exp_ready;
      logic        gid;
      logic [32:0] s;
      if (rst) begin
         m_state  = 0;
         m_cnt    = '0;
         m_loaded = 1'b0;
         m_prio   = 1'b0;
         m_ops    = '0;
         sb.delete();
      end
      exp_ready = 2'b00;
      if (m_state == 1) begin
         case (req_valid)
            2'b01:   exp_ready = 2'b01;
            2'b10:   exp_ready = 2'b10;
            2'b11:   exp_ready = m_prio ? 2'b10 : 2'b01;
            default: exp_ready = 2'b00;
         endcase
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(m_state == 3));
      check("key_loaded", 64'(key_loaded), 64'(m_loaded));
      check("op_count", 64'(op_count), 64'(m_ops));
      if (rst) begin
         check("rst_sum", 64'(rsp_sum), 64'd0);
         check("rst_id", 64'(rsp_id), 64'd0);
      end
      if (m_state == 3 && sb.size() > 0) begin
         check("rsp_sum", 64'(rsp_sum), 64'(sb[0][32:0]));
         check("rsp_id", 64'(rsp_id), 64'(sb[0][33]));
      end
      if (!rst) begin
         if (key_clear) begin
            m_state  = 0;
            m_cnt    = '0;
            m_loaded = 1'b0;
            sb.delete();
         end else begin
            case (m_state)
               0: if (key_valid) begin
                     if (m_cnt == 3'd7) begin
                        m_loaded = 1'b1;
                        m_state  = 1;
                     end
                     m_cnt = m_cnt + 3'd1;
                  end
               1: if ((exp_ready & req_valid) != 2'b00) begin
                     gid = exp_ready[1];
                     s   = {1'b0, req_a[32*gid +: 32]} + {1'b0, req_b[32*gid +: 32]};
                     sb.push_back({gid, s});
                     m_prio   = ~gid;
                     m_state  = 2;
                     last_gid = int'(gid);
                     xfer_count++;
                  end
               2: m_state = 3;
               default: if (rsp_ready) begin
                     void'(sb.pop_front());
                     m_ops   = m_ops + 1'b1;
                     m_state = 1;
                     done_count++;
                  end
            endcase
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_key();
      logic [63:0] k;
      k = GOLD_KEY;
      for (int i = 0; i < 8; i++) begin
         tick($urandom_range(0, 3));
         key_valid = 1'b1;
         key_byte  = k[8*i +: 8];
         tick();
         key_valid = 1'b0;
      end
      tick();
   endtask

   task automatic wait_xfer(input int target, input string tag);
      for (int i = 0; i < 60 && xfer_count < target; i++) tick();
      check(tag, 64'(xfer_count), 64'(target));
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int i = 0; i < 200 && done_count < target; i++) tick();
      check(tag, 64'(done_count), 64'(target));
   endtask

   task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b);
      int target;
      req_a[32*r +: 32] = a;
      req_b[32*r +: 32] = b;
      req_valid[r]      = 1'b1;
      target            = xfer_count + 1;
      wait_xfer(target, "op_xfer");
      req_valid = 2'b00;
   endtask

   task automatic run_both(input int n_ops);
      int target;
      int seen;
      target    = xfer_count + n_ops;
      seen      = xfer_count;
      req_valid = 2'b11;
      for (int i = 0; i < 6 * n_ops + 10 && xfer_count < target; i++) begin
         tick();
         if (xfer_count != seen) begin
            seen = xfer_count;
            req_a[32*last_gid +: 32] = $urandom();
            req_b[32*last_gid +: 32] = $urandom();
         end
      end
      check("both_xfer", 64'(xfer_count), 64'(target));
      req_valid = 2'b00;
   endtask

   initial begin
      int d;
      rst       = 1'b1;
      key_byte  = '0;
      key_valid = 1'b0;
      key_clear = 1'b0;
      req_valid = 2'b00;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);

      // Key load with idle gaps
      load_key();
      tick(2);

      // Carry-out into bit 32
      d = done_count + 1;
      do_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
      wait_done(d, "add_done");

      // Both requesters held valid; stray key bytes must be ignored
      req_a     = {32'd100, 32'd5};
      req_b     = {32'd200, 32'd7};
      key_valid = 1'b1;
      key_byte  = 8'h00;
      d = done_count + 8;
      run_both(8);
      key_valid = 1'b0;
      wait_done(d, "arb_done");

      // Backpressure in RESP
      rsp_ready = 1'b0;
      d = done_count + 1;
      do_op(1, 32'h1234_5678, 32'h9ABC_DEF0);
      tick(12);
      rsp_ready = 1'b1;
      wait_done(d, "bp_done");

      // Clear while in CALC
      do_op(0, 32'd11, 32'd22);
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      tick(3);
      // Clear together with a key byte: byte discarded
      key_clear = 1'b1;
      key_valid = 1'b1;
      key_byte  = 8'hEE;
      tick();
      key_clear = 1'b0;
      key_valid = 1'b0;
      load_key();
      d = done_count + 1;
      do_op(1, 32'h8000_0000, 32'h8000_0000);
      wait_done(d, "reload_done");

      // Reset pulsed in RESP
      rsp_ready = 1'b0;
      do_op(0, 32'd3, 32'd4);
      tick(2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      rsp_ready = 1'b1;
      tick(3);
      load_key();

      // Counter wrap past 0xF
      d = done_count + 18;
      run_both(18);
      wait_done(d, "wrap_done");
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
